// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_pkg: shared types and constants for the memory/IO bus controller.
//   - cpu bus command encodings (MNONE/MREAD/MWRITE, plus the illegal code)
//   - controller state enum and decoded target enum
//   - default addresses of the LED register and the switch input
//   - decode_target(): maps a 9-bit word address to its target
package mem_bus_pkg;

    localparam logic [1:0] MNONE    = 2'b00;
    localparam logic [1:0] MREAD    = 2'b01;
    localparam logic [1:0] MWRITE   = 2'b10;
    localparam logic [1:0] MILLEGAL = 2'b11;

    localparam logic [8:0] LED_ADDR_DEFAULT = 9'h100;
    localparam logic [8:0] SW_ADDR_DEFAULT  = 9'h140;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        T_RAM = 2'd0,
        T_LED = 2'd1,
        T_SW  = 2'd2,
        T_BAD = 2'd3
    } target_t;

    // The lower half of the address space is RAM; the upper half holds only
    // the two IO registers, everything else up there is an illegal access.
    function automatic target_t decode_target(
        input logic [8:0] addr,
        input logic [8:0] led_addr,
        input logic [8:0] sw_addr
    );
        target_t tgt;
        if (addr[8] == 1'b0) begin
            tgt = T_RAM;
        end else if (addr == led_addr) begin
            tgt = T_LED;
        end else if (addr == sw_addr) begin
            tgt = T_SW;
        end else begin
            tgt = T_BAD;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_sync2.sv
// sync2: parameterised-width two-flop synchroniser with asynchronous
// active-high reset. Each bit is synchronised independently; multi-bit
// inputs are assumed to be quasi-static (slide switches).
//   clk    in  1      destination clock
//   reset  in  1      asynchronous active-high reset, clears both stages
//   d      in  WIDTH  asynchronous input
//   q      out WIDTH  synchronised output, two clk edges behind d
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two back-to-back flops; only sync_r is safe to use downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: memory/IO bus controller sitting behind the cpu.
// Accepts one MREAD/MWRITE at a time in IDLE, latches it, performs the
// access in ACCESS (RAM, LED register, switch input or illegal address) and
// signals completion with a one-cycle mem_ready pulse in RESP.
//   clk, reset              rising-edge clock, async active-high reset
//   mem_cmd/mem_addr/
//   write_data              cpu command, word address, store data
//   read_data               registered load data, held until the next read
//   mem_ready               registered one-cycle completion pulse
//   ram_addr/ram_din/
//   ram_we/ram_re           synchronous RAM interface (decoded from state)
//   ram_dout                RAM read data, sampled on the RAM_LAT-th rising
//                           edge after the edge that raised ram_re
//   sw                      asynchronous switches (synchronised internally)
//   ledr                    LED register
//   bus_err                 sticky illegal-access flag, cleared only by reset
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int         RAM_LAT  = 1,
    parameter logic [8:0] LED_ADDR = LED_ADDR_DEFAULT,
    parameter logic [8:0] SW_ADDR  = SW_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        mem_ready,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_we,
    output logic        ram_re,
    input  logic [15:0] ram_dout,
    input  logic [9:0]  sw,
    output logic [7:0]  ledr,
    output logic        bus_err
);

    // Index of the final ACCESS cycle of a RAM read.
    localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);

    state_t      state_r;
    state_t      state_next_s;
    target_t     tgt_r;
    logic [2:0]  cnt_r;
    logic [8:0]  addr_r;
    logic [15:0] data_r;
    logic        is_write_r;
    logic [15:0] read_data_r;
    logic        mem_ready_r;
    logic [7:0]  ledr_r;
    logic        bus_err_r;
    logic [9:0]  sw_sync_s;

    logic        accept_s;
    logic        illegal_s;
    logic        ram_read_s;
    logic        last_access_s;
    logic        rd_load_s;
    logic [15:0] rd_value_s;
    logic        led_load_s;
    logic        err_set_s;
    logic        ram_re_s;
    logic        ram_we_s;
    logic [7:0]  ram_addr_s;
    logic [15:0] ram_din_s;

    sync2 #(.WIDTH(10)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (sw_sync_s)
    );

    // Classify the incoming cpu command.
    always_comb begin
        accept_s  = 1'b0;
        illegal_s = 1'b0;
        case (mem_cmd)
            MREAD, MWRITE: accept_s  = 1'b1;
            MILLEGAL:      illegal_s = 1'b1;
            default: begin
                accept_s  = 1'b0;
                illegal_s = 1'b0;
            end
        endcase
    end

    // A RAM read is the only access that lasts more than one ACCESS cycle.
    always_comb begin
        ram_read_s = (tgt_r == T_RAM) && !is_write_r;
        if (state_r == ACCESS) begin
            last_access_s = !ram_read_s || (cnt_r == LAT_LAST);
        end else begin
            last_access_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (last_access_s) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = ACCESS;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: RAM strobes only in the first ACCESS cycle, driven purely
    // from latched values so no cpu input reaches the RAM combinationally.
    always_comb begin
        ram_re_s   = 1'b0;
        ram_we_s   = 1'b0;
        ram_addr_s = 8'h00;
        ram_din_s  = 16'h0000;
        if ((state_r == ACCESS) && (cnt_r == 3'd0) && (tgt_r == T_RAM)) begin
            ram_re_s   = !is_write_r;
            ram_we_s   = is_write_r;
            ram_addr_s = addr_r[7:0];
            ram_din_s  = is_write_r ? data_r : 16'h0000;
        end else begin
            ram_re_s   = 1'b0;
            ram_we_s   = 1'b0;
        end
    end

    // Effects of completing an access, or of an illegal command in IDLE.
    always_comb begin
        rd_load_s  = 1'b0;
        rd_value_s = read_data_r;
        led_load_s = 1'b0;
        err_set_s  = 1'b0;
        if (state_r == IDLE) begin
            err_set_s = illegal_s;
        end else if (last_access_s) begin
            case (tgt_r)
                T_RAM: begin
                    rd_load_s  = !is_write_r;
                    rd_value_s = ram_dout;
                end
                T_LED: begin
                    led_load_s = is_write_r;
                    rd_load_s  = !is_write_r;
                    rd_value_s = {8'h00, ledr_r};
                end
                T_SW: begin
                    rd_load_s  = !is_write_r;
                    rd_value_s = {6'b00_0000, sw_sync_s};
                end
                T_BAD: begin
                    err_set_s  = 1'b1;
                    rd_load_s  = !is_write_r;
                    rd_value_s = 16'h0000;
                end
                default: begin
                    rd_load_s = 1'b0;
                end
            endcase
        end else begin
            rd_load_s = 1'b0;
        end
    end

    // Latch the accepted transaction and run the RAM latency counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r     <= 9'h000;
            data_r     <= 16'h0000;
            is_write_r <= 1'b0;
            tgt_r      <= T_RAM;
            cnt_r      <= 3'd0;
        end else if ((state_r == IDLE) && accept_s) begin
            addr_r     <= mem_addr;
            data_r     <= write_data;
            is_write_r <= (mem_cmd == MWRITE);
            tgt_r      <= decode_target(mem_addr, LED_ADDR, SW_ADDR);
            cnt_r      <= 3'd0;
        end else if (state_r == ACCESS) begin
            cnt_r      <= cnt_r + 3'd1;
        end else begin
            cnt_r      <= 3'd0;
        end
    end

    // Registered cpu-facing outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_r <= 16'h0000;
            mem_ready_r <= 1'b0;
            ledr_r      <= 8'h00;
            bus_err_r   <= 1'b0;
        end else begin
            mem_ready_r <= last_access_s;
            if (rd_load_s) begin
                read_data_r <= rd_value_s;
            end
            if (led_load_s) begin
                ledr_r <= data_r[7:0];
            end
            if (err_set_s) begin
                bus_err_r <= 1'b1;
            end
        end
    end

    assign read_data = read_data_r;
    assign mem_ready = mem_ready_r;
    assign ledr      = ledr_r;
    assign bus_err   = bus_err_r;
    assign ram_re    = ram_re_s;
    assign ram_we    = ram_we_s;
    assign ram_addr  = ram_addr_s;
    assign ram_din   = ram_din_s;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: self-checking bench for mem_bus_ctrl. Two instances run
// side by side (RAM_LAT = 1 and RAM_LAT = 3) sharing clock and reset. A
// transaction-level reference model (address map, RAM contents, LED value,
// sticky error flag, last read value) predicts every result; a simple RAM
// model serves each instance and presents read data only in the one cycle
// in which the controller must sample it.
module tb_mem_bus_ctrl;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_READ  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] C_ILL   = 2'b11;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cmd   [2];
    logic [8:0]  addr  [2];
    logic [15:0] wd    [2];
    logic [15:0] rd    [2];
    logic        rdy   [2];
    logic [7:0]  raddr [2];
    logic [15:0] rdin  [2];
    logic        rwe   [2];
    logic        rre   [2];
    logic [15:0] rdout [2];
    logic [9:0]  sw    [2];
    logic [7:0]  led   [2];
    logic        berr  [2];

    always #5 clk = ~clk;

    mem_bus_ctrl #(.RAM_LAT(LAT0)) u0 (
        .clk(clk), .reset(reset), .mem_cmd(cmd[0]), .mem_addr(addr[0]),
        .write_data(wd[0]), .read_data(rd[0]), .mem_ready(rdy[0]),
        .ram_addr(raddr[0]), .ram_din(rdin[0]), .ram_we(rwe[0]), .ram_re(rre[0]),
        .ram_dout(rdout[0]), .sw(sw[0]), .ledr(led[0]), .bus_err(berr[0])
    );

    mem_bus_ctrl #(.RAM_LAT(LAT1)) u1 (
        .clk(clk), .reset(reset), .mem_cmd(cmd[1]), .mem_addr(addr[1]),
        .write_data(wd[1]), .read_data(rd[1]), .mem_ready(rdy[1]),
        .ram_addr(raddr[1]), .ram_din(rdin[1]), .ram_we(rwe[1]), .ram_re(rre[1]),
        .ram_dout(rdout[1]), .sw(sw[1]), .ledr(led[1]), .bus_err(berr[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    // ---------------- RAM models ----------------
    logic [15:0] ramm  [2][256];
    logic [15:0] rv    [2];
    logic [15:0] noise [2];
    int          due   [2] = '{-100, -100};
    int          ncyc = 0;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rwe[d]) ramm[d][raddr[d]] <= rdin[d];
        end
    end

    // Read data appears only in the cycle ending with the RAM_LAT-th edge
    // after the ram_re cycle began; every other cycle carries random junk.
    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        for (int d = 0; d < 2; d++) begin
            noise[d] <= 16'($urandom);
            if (rre[d]) begin
                due[d] <= ncyc + lat_of(d);
                rv[d]  <= ramm[d][raddr[d]];
            end
        end
    end

    assign rdout[0] = (due[0] == ncyc) ? rv[0] : noise[0];
    assign rdout[1] = (due[1] == ncyc) ? rv[1] : noise[1];

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [2][256];
    logic [7:0]  m_led   [2];
    logic        m_err   [2];
    logic [15:0] m_rd    [2];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s (dut%0d): observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_led[d] = 8'h00;
            m_err[d] = 1'b0;
            m_rd[d]  = 16'h0000;
        end
    endtask

    task automatic chk_quiet(input string tag, input int d);
        chk({tag, " read_data"}, d, 32'(rd[d]), 32'(m_rd[d]));
        chk({tag, " mem_ready"}, d, 32'(rdy[d]), 32'd0);
        chk({tag, " ledr"},      d, 32'(led[d]), 32'(m_led[d]));
        chk({tag, " bus_err"},   d, 32'(berr[d]), 32'(m_err[d]));
        chk({tag, " ram_strb"},  d, {30'd0, rwe[d], rre[d]}, 32'd0);
        chk({tag, " ram_bus"},   d, {8'h00, raddr[d], rdin[d]}, 32'd0);
    endtask

    // One complete cpu transaction on instance d, checked against the model.
    task automatic txn(input int d, input logic [1:0] c, input logic [8:0] a, input logic [15:0] w);
        int k, nre, nwe, exp_lat, exp_re, exp_we;
        bit seen;
        exp_lat = 2; exp_re = 0; exp_we = 0;
        if (c == C_READ) begin
            if (a[8] == 1'b0) begin
                m_rd[d] = ref_mem[d][a[7:0]];
                exp_lat = lat_of(d) + 1;
                exp_re  = 1;
            end else if (a == 9'h100) begin
                m_rd[d] = {8'h00, m_led[d]};
            end else if (a == 9'h140) begin
                m_rd[d] = {6'b000000, sw[d]};
            end else begin
                m_rd[d]  = 16'h0000;
                m_err[d] = 1'b1;
            end
        end else begin
            if (a[8] == 1'b0) begin
                ref_mem[d][a[7:0]] = w;
                exp_we = 1;
            end else if (a == 9'h100) begin
                m_led[d] = w[7:0];
            end else if (a != 9'h140) begin
                m_err[d] = 1'b1;
            end
        end
        @(posedge clk); #1;
        cmd[d] = c; addr[d] = a; wd[d] = w;
        k = 0; nre = 0; nwe = 0; seen = 1'b0;
        while (!seen && k < 16) begin
            @(negedge clk);
            if (rre[d]) begin
                nre++;
                chk("ram_addr(rd)", d, 32'(raddr[d]), 32'(a[7:0]));
            end
            if (rwe[d]) begin
                nwe++;
                chk("ram_addr(wr)", d, 32'(raddr[d]), 32'(a[7:0]));
                chk("ram_din", d, 32'(rdin[d]), 32'(w));
            end
            if (rdy[d]) begin
                seen = 1'b1;
            end else begin
                // the request is latched by now; the bus may wander freely
                if (k >= 1) begin
                    addr[d] = 9'($urandom);
                    wd[d]   = 16'($urandom);
                end
                k++;
            end
        end
        cmd[d] = C_NONE;
        chk("latency", d, 32'(k), 32'(exp_lat));
        chk("ram_re count", d, 32'(nre), 32'(exp_re));
        chk("ram_we count", d, 32'(nwe), 32'(exp_we));
        chk("read_data", d, 32'(rd[d]), 32'(m_rd[d]));
        chk("ledr", d, 32'(led[d]), 32'(m_led[d]));
        chk("bus_err", d, 32'(berr[d]), 32'(m_err[d]));
        @(negedge clk);
        chk("mem_ready pulse width", d, 32'(rdy[d]), 32'd0);
    endtask

    task automatic illegal(input int d);
        @(posedge clk); #1;
        cmd[d] = C_ILL;
        @(posedge clk); #1;
        cmd[d] = C_NONE;
        m_err[d] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no ready on 2'b11", d, 32'(rdy[d]), 32'd0);
        end
        chk("bus_err after 2'b11", d, 32'(berr[d]), 32'(m_err[d]));
    endtask

    initial begin
        int d, r;
        logic [1:0]  c;
        logic [8:0]  a;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cmd[i] = C_NONE; addr[i] = 9'h000; wd[i] = 16'h0000; sw[i] = 10'h000;
        end
        model_reset();
        repeat (3) @(negedge clk);
        chk_quiet("reset", 0);
        chk_quiet("reset", 1);
        reset = 1'b0;

        // fill a pool of RAM words in both instances
        for (int i = 0; i < 32; i++) begin
            txn(0, C_WRITE, 9'(i), 16'($urandom));
            txn(1, C_WRITE, 9'(i), 16'($urandom));
        end

        // 1: RAM write then read back
        txn(0, C_WRITE, 9'h005, 16'hABCD);
        txn(0, C_READ,  9'h005, 16'h0000);
        chk("t1 read_data", 0, 32'(rd[0]), 32'h0000ABCD);

        // 2: LED register
        txn(0, C_WRITE, 9'h100, 16'h12F5);
        chk("t2 ledr", 0, 32'(led[0]), 32'h000000F5);
        txn(0, C_READ,  9'h100, 16'h0000);
        chk("t2 read_data", 0, 32'(rd[0]), 32'h000000F5);

        // 3: switch input and dropped switch write
        sw[0] = 10'h3FF;
        repeat (3) @(posedge clk);
        txn(0, C_READ,  9'h140, 16'h0000);
        chk("t3 read_data", 0, 32'(rd[0]), 32'h000003FF);
        txn(0, C_WRITE, 9'h140, 16'hFFFF);

        // 4: illegal address, illegal command, sticky bus_err
        txn(0, C_READ, 9'h180, 16'h0000);
        chk("t4 read_data", 0, 32'(rd[0]), 32'h00000000);
        illegal(0);
        repeat (10) @(negedge clk);
        chk("t4 bus_err sticky", 0, 32'(berr[0]), 32'd1);

        // 5: RAM read with latency 3
        txn(1, C_WRITE, 9'h0FF, 16'h5A5A);
        txn(1, C_READ,  9'h0FF, 16'h0000);
        chk("t5 read_data", 1, 32'(rd[1]), 32'h00005A5A);

        // 6: reset during the second ACCESS cycle of a latency-3 read
        @(posedge clk); #1;
        cmd[1] = C_READ; addr[1] = 9'h0FF;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        cmd[1] = C_NONE;
        model_reset();
        chk_quiet("t6 in reset", 0);
        chk_quiet("t6 in reset", 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t6 no ready after abort", 1, 32'(rdy[1]), 32'd0);
        end
        txn(1, C_READ, 9'h0FF, 16'h0000);
        chk("t6 read after reset", 1, 32'(rd[1]), 32'h00005A5A);

        // randomized traffic
        for (int i = 0; i < 120; i++) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                illegal(d);
            end else if (r == 1) begin
                sw[d] = 10'($urandom);
                repeat (3) @(posedge clk);
            end else begin
                c = ($urandom_range(0, 1) == 0) ? C_READ : C_WRITE;
                case ($urandom_range(0, 8))
                    6: a = 9'h100;
                    7: a = 9'h140;
                    8: begin
                        a = {1'b1, 8'($urandom)};
                        if (a == 9'h100 || a == 9'h140) a = 9'h1FF;
                    end
                    default: a = 9'($urandom_range(0, 31));
                endcase
                txn(d, c, a, 16'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
